// File: rtl/commit_unit_pkg.sv
// Shared types and constants for the commit stage: entry layout, arch codes, FSM states.
package commit_unit_pkg;

  localparam int unsigned PHYS_BITS    = 6;
  localparam int unsigned ARCH_BITS    = 3;
  localparam int unsigned NUM_ARCH     = 6;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned NUM_SLOTS    = 3;
  localparam int unsigned ENTRY_W      = 1 + ARCH_BITS + PHYS_BITS;

  localparam int unsigned PHYS_LSB  = 0;
  localparam int unsigned ARCH_LSB  = PHYS_BITS;
  localparam int unsigned FLUSH_BIT = PHYS_BITS + ARCH_BITS;

  localparam int unsigned CTR_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [ARCH_BITS-1:0] ARCH_NONE = 3'd0;
  localparam logic [ARCH_BITS-1:0] ARCH_A    = 3'd1;
  localparam logic [ARCH_BITS-1:0] ARCH_X    = 3'd2;
  localparam logic [ARCH_BITS-1:0] ARCH_Y    = 3'd3;
  localparam logic [ARCH_BITS-1:0] ARCH_SP   = 3'd4;
  localparam logic [ARCH_BITS-1:0] ARCH_P    = 3'd5;

  typedef struct packed {
    logic                 flush;
    logic [ARCH_BITS-1:0] arch;
    logic [PHYS_BITS-1:0] phys;
  } entry_t;

  typedef enum logic [0:0] {
    StRun,
    StFlush
  } state_e;

  function automatic entry_t unpack_entry(logic [ENTRY_W-1:0] raw);
    entry_t e;
    e.flush = raw[FLUSH_BIT];
    e.arch  = raw[ARCH_LSB +: ARCH_BITS];
    e.phys  = raw[PHYS_LSB +: PHYS_BITS];
    return e;
  endfunction

endpackage

// File: rtl/commit_unit_rrat_file.sv
// Retirement RAT: one phys tag per arch register, three write ports applied in slot order
// so later ports observe earlier ports' writes within the same cycle.
module commit_unit_rrat_file
  import commit_unit_pkg::*;
(
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_SLOTS-1:0]                  we_i,
  input  logic [NUM_SLOTS-1:0][ARCH_BITS-1:0]   waddr_i,
  input  logic [NUM_SLOTS-1:0][PHYS_BITS-1:0]   wdata_i,
  output logic [NUM_SLOTS-1:0][PHYS_BITS-1:0]   old_o,
  output logic [NUM_ARCH*PHYS_BITS-1:0]         rrat_o
);

  logic [NUM_ARCH-1:0][PHYS_BITS-1:0] rrat_q, rrat_d;

  always_comb begin
    rrat_d = rrat_q;
    old_o  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      // Codes past the last arch reg have no storage; such writes are dropped.
      if (we_i[i] && (waddr_i[i] < ARCH_BITS'(NUM_ARCH))) begin
        old_o[i]             = rrat_d[waddr_i[i]];
        rrat_d[waddr_i[i]]   = wdata_i[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_ARCH; r++) begin
        rrat_q[r] <= PHYS_BITS'(r);
      end
    end else begin
      rrat_q <= rrat_d;
    end
  end

  assign rrat_o = rrat_q;

endmodule

// File: rtl/commit_unit.sv
// In-order commit stage: retires up to three ROB entries per cycle, maintains the
// retirement RAT, frees superseded tags and opens a recovery window on a flush entry.
module commit_unit
  import commit_unit_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SLOTS*ENTRY_W-1:0]  rob_dout,
  output logic [2:0]                    rob_ready_ct,
  output logic [NUM_SLOTS*PHYS_BITS-1:0] free_tags,
  output logic [NUM_SLOTS-1:0]          free_valid,
  output logic [NUM_ARCH*PHYS_BITS-1:0] rrat_out,
  output logic                          flush,
  output logic [15:0]                   retire_count
);

  state_e                              state_q, state_d;
  logic [CTR_W-1:0]                    ctr_q, ctr_d;
  logic [2:0]                          req_ct_q;
  logic [NUM_SLOTS-1:0][PHYS_BITS-1:0] free_tags_q, free_tags_d;
  logic [NUM_SLOTS-1:0]                free_valid_q, free_valid_d;
  logic [15:0]                         retire_count_q, retire_count_d;

  entry_t                              slot [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]                live, commit, we, sq_free;
  logic                                group_flush;
  logic [1:0]                          n_commit;
  logic [NUM_SLOTS-1:0][ARCH_BITS-1:0] waddr;
  logic [NUM_SLOTS-1:0][PHYS_BITS-1:0] wdata, old_tag;

  // Slot classification; once a flush slot commits, every younger live slot is squashed.
  always_comb begin
    live        = '0;
    commit      = '0;
    we          = '0;
    sq_free     = '0;
    group_flush = 1'b0;
    n_commit    = '0;
    waddr       = '0;
    wdata       = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot[i]  = unpack_entry(rob_dout[ENTRY_W*i +: ENTRY_W]);
      waddr[i] = slot[i].arch;
      wdata[i] = slot[i].phys;
      live[i]  = 3'(i) < req_ct_q;
      if (live[i]) begin
        if (group_flush) begin
          sq_free[i] = slot[i].arch != ARCH_NONE;
        end else if (slot[i].flush || (slot[i].arch != ARCH_NONE)) begin
          commit[i]   = 1'b1;
          we[i]       = slot[i].arch != ARCH_NONE;
          group_flush = slot[i].flush;
        end
      end
      n_commit = n_commit + 2'(commit[i]);
    end
  end

  commit_unit_rrat_file u_rrat (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .old_o   (old_tag),
    .rrat_o  (rrat_out)
  );

  always_comb begin
    free_valid_d   = '0;
    free_tags_d    = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      free_valid_d[i] = we[i] | sq_free[i];
      free_tags_d[i]  = we[i] ? old_tag[i] : slot[i].phys;
    end
    retire_count_d = retire_count_q + 16'(n_commit);
  end

  // Request nothing once a flush is seen so no younger group reaches commit.
  assign rob_ready_ct = ((state_q == StRun) && !group_flush) ? 3'd3 : 3'd0;
  assign flush        = (state_q == StFlush);
  assign free_tags    = free_tags_q;
  assign free_valid   = free_valid_q;
  assign retire_count = retire_count_q;

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    unique case (state_q)
      StRun: begin
        if (group_flush) begin
          state_d = StFlush;
          ctr_d   = CTR_W'(FLUSH_CYCLES - 1);
        end
      end
      StFlush: begin
        if (ctr_q == '0) begin
          state_d = StRun;
        end else begin
          ctr_d = ctr_q - 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StRun;
      ctr_q          <= '0;
      req_ct_q       <= '0;
      free_tags_q    <= '0;
      free_valid_q   <= '0;
      retire_count_q <= '0;
    end else begin
      state_q        <= state_d;
      ctr_q          <= ctr_d;
      req_ct_q       <= rob_ready_ct;
      free_tags_q    <= free_tags_d;
      free_valid_q   <= free_valid_d;
      retire_count_q <= retire_count_d;
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// Bench for commit_unit: ROB emulation with directed and random groups, a queue-based
// scoreboard fed by a slot-by-slot reference model, and an independent monitor.
module tb_commit_unit;
  import commit_unit_pkg::*;

  logic                           clk = 1'b0;
  logic                           rst;
  logic [NUM_SLOTS*ENTRY_W-1:0]   rob_dout;
  logic [2:0]                     rob_ready_ct;
  logic [NUM_SLOTS*PHYS_BITS-1:0] free_tags;
  logic [NUM_SLOTS-1:0]           free_valid;
  logic [NUM_ARCH*PHYS_BITS-1:0]  rrat_out;
  logic                           flush;
  logic [15:0]                    retire_count;

  always #5 clk = ~clk;

  commit_unit dut (
    .clk          (clk),
    .rst          (rst),
    .rob_dout     (rob_dout),
    .rob_ready_ct (rob_ready_ct),
    .free_tags    (free_tags),
    .free_valid   (free_valid),
    .rrat_out     (rrat_out),
    .flush        (flush),
    .retire_count (retire_count)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned                    stamp;
    logic [2:0]                     fv;
    logic [NUM_SLOTS*PHYS_BITS-1:0] tags;
    logic [NUM_ARCH*PHYS_BITS-1:0]  rrat;
    logic [15:0]                    count;
  } out_exp_t;

  typedef struct {
    int unsigned stamp;
    logic [2:0]  ready;
    logic        flush;
  } ctl_exp_t;

  out_exp_t out_q[$];
  ctl_exp_t ctl_q[$];
  out_exp_t mon_oe;
  ctl_exp_t mon_ce;

  int  checks = 0;
  int  passed = 0;
  bit  mon_en = 1'b0;

  logic [PHYS_BITS-1:0] m_rrat [NUM_ARCH];
  logic [15:0]          m_count;
  int                   flush_left;
  int                   r_cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    for (int r = 0; r < NUM_ARCH; r++) m_rrat[r] = PHYS_BITS'(r);
    m_count    = '0;
    flush_left = 0;
  endtask

  function automatic logic [NUM_ARCH*PHYS_BITS-1:0] pack_rrat();
    logic [NUM_ARCH*PHYS_BITS-1:0] v;
    for (int r = 0; r < NUM_ARCH; r++) v[PHYS_BITS*r +: PHYS_BITS] = m_rrat[r];
    return v;
  endfunction

  function automatic logic [ENTRY_W-1:0] mk(bit f, int a, int p);
    return {f, ARCH_BITS'(a), PHYS_BITS'(p)};
  endfunction

  function automatic logic [NUM_SLOTS*ENTRY_W-1:0] rand_grp(int live);
    logic [NUM_SLOTS*ENTRY_W-1:0] g;
    int nret;
    nret = $urandom_range(0, 3);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (i < live) begin
        if (i < nret) g[ENTRY_W*i +: ENTRY_W] = mk($urandom_range(0, 7) == 0,
                                                     $urandom_range(0, NUM_ARCH-1),
                                                     $urandom_range(0, 63));
        else          g[ENTRY_W*i +: ENTRY_W] = '0;
      end else begin
        g[ENTRY_W*i +: ENTRY_W] = ENTRY_W'($urandom);  // stale slot contents
      end
    end
    return g;
  endfunction

  // Drive one cycle of ROB data, predict its effects, then advance to the next cycle.
  task automatic run_cycle(input logic [NUM_SLOTS*ENTRY_W-1:0] grp, input bit rst_here);
    out_exp_t             oe;
    ctl_exp_t             ce;
    bit                   found;
    logic [ENTRY_W-1:0]   e;
    logic                 f;
    logic [ARCH_BITS-1:0] a;
    logic [PHYS_BITS-1:0] p;
    int                   r_next;
    rob_dout = grp;
    rst      = rst_here;
    found    = 1'b0;
    ce.stamp = cyc;
    ce.flush = flush_left > 0;
    oe.stamp = cyc + 1;
    oe.fv    = '0;
    oe.tags  = '0;
    for (int i = 0; i < r_cur; i++) begin
      e = grp[ENTRY_W*i +: ENTRY_W];
      f = e[ENTRY_W-1];
      a = e[PHYS_BITS +: ARCH_BITS];
      p = e[PHYS_BITS-1:0];
      if (found) begin
        if (a != 0) begin
          oe.fv[i] = 1'b1;
          oe.tags[PHYS_BITS*i +: PHYS_BITS] = p;
        end
      end else if (a != 0 || f) begin
        if (a != 0) begin
          oe.fv[i] = 1'b1;
          oe.tags[PHYS_BITS*i +: PHYS_BITS] = m_rrat[a];
          m_rrat[a] = p;
        end
        m_count++;
        if (f) found = 1'b1;
      end
    end
    ce.ready = (flush_left == 0 && !found) ? 3'd3 : 3'd0;
    if (flush_left > 0) flush_left--;
    else if (found)     flush_left = FLUSH_CYCLES;
    if (rst_here) begin
      model_reset();
      oe.fv   = '0;
      oe.tags = '0;
    end
    oe.rrat  = pack_rrat();
    oe.count = m_count;
    ctl_q.push_back(ce);
    out_q.push_back(oe);
    @(negedge clk);
    r_next = rst_here ? 0 : int'(rob_ready_ct);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    r_cur = r_next;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ctl_q.size() > 0 && ctl_q[0].stamp == cyc) begin
        mon_ce = ctl_q.pop_front();
        check("rob_ready_ct", 64'(rob_ready_ct), 64'(mon_ce.ready));
        check("flush", 64'(flush), 64'(mon_ce.flush));
      end
      if (out_q.size() > 0 && out_q[0].stamp == cyc) begin
        logic [NUM_SLOTS*PHYS_BITS-1:0] mask;
        mon_oe = out_q.pop_front();
        mask   = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
          if (mon_oe.fv[i]) mask[PHYS_BITS*i +: PHYS_BITS] = '1;
        check("free_valid", 64'(free_valid), 64'(mon_oe.fv));
        check("free_tags", 64'(free_tags & mask), 64'(mon_oe.tags));
        check("rrat_out", 64'(rrat_out), 64'(mon_oe.rrat));
        check("retire_count", 64'(retire_count), 64'(mon_oe.count));
      end else begin
        check("free_valid_idle", 64'(free_valid), 64'd0);
      end
    end
  end

  initial begin
    logic [NUM_SLOTS*ENTRY_W-1:0] g;
    rst      = 1'b1;
    rob_dout = '0;
    model_reset();
    r_cur = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rrat", 64'(rrat_out), 64'(pack_rrat()));
    check("reset_ready", 64'(rob_ready_ct), 64'd3);
    check("reset_flush", 64'(flush), 64'd0);
    check("reset_count", 64'(retire_count), 64'd0);
    check("reset_free_valid", 64'(free_valid), 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    run_cycle('0, 1'b0);
    // Two plain commits plus an empty slot.
    run_cycle({mk(0, 0, 0), mk(0, ARCH_X, 11), mk(0, ARCH_A, 10)}, 1'b0);
    // Same arch written three times in one group.
    run_cycle({mk(0, ARCH_A, 14), mk(0, ARCH_A, 13), mk(0, ARCH_A, 12)}, 1'b0);
    // Flush in slot 1 squashes slot 2.
    run_cycle({mk(0, ARCH_A, 22), mk(1, ARCH_X, 21), mk(0, ARCH_Y, 20)}, 1'b0);
    // ROB holds stale data while nothing is requested.
    run_cycle({mk(0, ARCH_A, 22), mk(1, ARCH_X, 21), mk(0, ARCH_Y, 20)}, 1'b0);
    run_cycle({mk(1, ARCH_P, 33), mk(0, ARCH_SP, 32), mk(0, ARCH_A, 31)}, 1'b0);
    // Only the oldest slot retired.
    run_cycle({mk(0, 0, 0), mk(0, 0, 0), mk(0, ARCH_Y, 30)}, 1'b0);
    // Flush with no destination, then reset inside the recovery window.
    run_cycle({mk(0, ARCH_P, 42), mk(0, ARCH_SP, 41), mk(1, 0, 40)}, 1'b0);
    run_cycle({mk(0, ARCH_P, 52), mk(0, ARCH_SP, 51), mk(0, ARCH_A, 50)}, 1'b1);
    run_cycle('0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      g = rand_grp(r_cur);
      run_cycle(g, $urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(out_q.size() + ctl_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
